mem_port_arbiter: RTL and testbench

- Sequences and shares the CPU's single-port synchronous Memory between two requesters: the CPU fetch/load/store path (port A) and a DMA/program-loader path (port B).
- Fixed priority to port A, with a starvation limit that guarantees port B forward progress.
- Owns the Memory Address, DIn and Write_EN inputs and returns read data plus a one-cycle Ack to the winning requester.

---
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter that time-shares a single-port synchronous memory between port A
// (priority) and port B, with a starvation limit that forces B through.
module mem_port_arbiter #(
  parameter int DataWidth   = 8,
  parameter int AddrWidth   = 8,
  parameter int StarveLimit = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 A_Req,
  input  logic                 A_Wr,
  input  logic [AddrWidth-1:0] A_Addr,
  input  logic [DataWidth-1:0] A_DIn,
  output logic                 A_Ack,
  output logic [DataWidth-1:0] A_DOut,
  input  logic                 B_Req,
  input  logic                 B_Wr,
  input  logic [AddrWidth-1:0] B_Addr,
  input  logic [DataWidth-1:0] B_DIn,
  output logic                 B_Ack,
  output logic [DataWidth-1:0] B_DOut,
  output logic [AddrWidth-1:0] MEM_Addr,
  output logic [DataWidth-1:0] MEM_DIn,
  output logic                 MEM_WrEn,
  input  logic [DataWidth-1:0] MEM_DOut,
  output logic                 Busy,
  output logic                 Owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  localparam logic [3:0] Limit = 4'(StarveLimit);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       cur_wr;
  logic       grant_b;

  // B wins when A is quiet, or when A has already had its allowed run of grants
  always_comb begin
    grant_b = B_Req && (!A_Req || (starve_cnt == Limit));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      cur_wr     <= 1'b0;
      A_Ack      <= 1'b0;
      A_DOut     <= '0;
      B_Ack      <= 1'b0;
      B_DOut     <= '0;
      MEM_Addr   <= '0;
      MEM_DIn    <= '0;
      MEM_WrEn   <= 1'b0;
      Busy       <= 1'b0;
      Owner      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (A_Req || B_Req) begin
            state    <= ISSUE;
            Busy     <= 1'b1;
            Owner    <= grant_b;
            MEM_Addr <= grant_b ? B_Addr : A_Addr;
            MEM_DIn  <= grant_b ? B_DIn : A_DIn;
            MEM_WrEn <= grant_b ? B_Wr : A_Wr;
            cur_wr   <= grant_b ? B_Wr : A_Wr;
            // Count only A grants that made a waiting B lose
            if (grant_b || !B_Req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != Limit) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ISSUE: begin
          state    <= CAPTURE;
          MEM_WrEn <= 1'b0;
        end
        CAPTURE: begin
          state <= DONE;
          if (Owner) begin
            B_Ack <= 1'b1;
            if (!cur_wr) B_DOut <= MEM_DOut;
          end else begin
            A_Ack <= 1'b1;
            if (!cur_wr) A_DOut <= MEM_DOut;
          end
        end
        DONE: begin
          state <= IDLE;
          A_Ack <= 1'b0;
          B_Ack <= 1'b0;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model with its own memory image.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       A_Req = 1'b0, A_Wr = 1'b0, B_Req = 1'b0, B_Wr = 1'b0;
  logic [7:0] A_Addr = '0, A_DIn = '0, B_Addr = '0, B_DIn = '0;
  logic       A_Ack, B_Ack, MEM_WrEn, Busy, Owner;
  logic [7:0] A_DOut, B_DOut, MEM_Addr, MEM_DIn;
  logic [7:0] MEM_DOut = '0;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = '0, bd_data = '0;

  int n_cmp = 0;
  int n_fail = 0;

  mem_port_arbiter #(.DataWidth(8), .AddrWidth(8), .StarveLimit(LIMIT)) dut (
    .Clk(Clk), .Reset(Reset),
    .A_Req(A_Req), .A_Wr(A_Wr), .A_Addr(A_Addr), .A_DIn(A_DIn), .A_Ack(A_Ack), .A_DOut(A_DOut),
    .B_Req(B_Req), .B_Wr(B_Wr), .B_Addr(B_Addr), .B_DIn(B_DIn), .B_Ack(B_Ack), .B_DOut(B_DOut),
    .MEM_Addr(MEM_Addr), .MEM_DIn(MEM_DIn), .MEM_WrEn(MEM_WrEn), .MEM_DOut(MEM_DOut),
    .Busy(Busy), .Owner(Owner)
  );

  always #5 Clk = ~Clk;

  // Single-port synchronous memory with a backdoor write for preloading
  always @(posedge Clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (MEM_WrEn) mem[MEM_Addr] <= MEM_DIn;
    MEM_DOut <= mem[MEM_Addr];
  end

  task automatic do_reset();
    A_Req = 1'b0; B_Req = 1'b0;
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic backdoor_write(input logic [7:0] addr, input logic [7:0] data);
    bd_we = 1'b1; bd_addr = addr; bd_data = data;
    ref_mem[addr] = data;
    @(negedge Clk);
    bd_we = 1'b0;
  endtask

  // Drives one access from an idle IDLE cycle and reports what was observed up to its Ack
  task automatic run_access(input bit port, input bit wr, input logic [7:0] addr, input logic [7:0] data,
                            output int lat, output logic [7:0] dout, output int wren_n,
                            output int busy_n, output logic [7:0] wren_addr, output logic owner);
    lat = -1; dout = '0; wren_n = 0; busy_n = 0; wren_addr = '0; owner = 1'b0;
    @(negedge Clk);
    if (port) begin B_Req = 1'b1; B_Wr = wr; B_Addr = addr; B_DIn = data; end
    else      begin A_Req = 1'b1; A_Wr = wr; A_Addr = addr; A_DIn = data; end
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (MEM_WrEn) begin wren_n++; wren_addr = MEM_Addr; end
      if (Busy) busy_n++;
      if (port ? B_Ack : A_Ack) begin
        lat = n; dout = port ? B_DOut : A_DOut; owner = Owner;
        break;
      end
    end
    A_Req = 1'b0; B_Req = 1'b0;
  endtask

  // Both ports re-request in the IDLE cycle right after their own Ack; records who was served
  task automatic collect_grants(input int n, output logic [15:0] order, output int got);
    bit ra, rb;
    order = '0; got = 0; ra = 1'b0; rb = 1'b0;
    for (int c = 0; c < 40 * n && got < n; c++) begin
      @(negedge Clk);
      if (ra) begin A_Req = 1'b1; ra = 1'b0; end
      if (rb) begin B_Req = 1'b1; rb = 1'b0; end
      if (A_Ack) begin order[got] = 1'b0; got++; A_Req = 1'b0; ra = 1'b1; end
      else if (B_Ack) begin order[got] = 1'b1; got++; B_Req = 1'b0; rb = 1'b1; end
    end
    A_Req = 1'b0; B_Req = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    n_cmp++;
    if ({A_Ack, B_Ack, MEM_WrEn, Busy, Owner} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b want 00000", {A_Ack, B_Ack, MEM_WrEn, Busy, Owner});
    end
    n_cmp++;
    if ({A_DOut, B_DOut, MEM_Addr, MEM_DIn} !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_data: got %h want 00000000", {A_DOut, B_DOut, MEM_Addr, MEM_DIn});
    end
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    n_cmp++;
    if (Busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_idle_busy: got %b want 0", Busy); end
  endtask

  task automatic test_single_read();
    int lat, wren_n, busy_n; logic [7:0] dout, waddr; logic own;
    backdoor_write(8'h10, 8'h5A);
    run_access(1'b0, 1'b0, 8'h10, 8'h00, lat, dout, wren_n, busy_n, waddr, own);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL read_latency: got %0d want 3", lat); end
    n_cmp++; if (dout !== 8'h5A) begin n_fail++; $display("[TB] FAIL read_a_dout: got %h want 5a", dout); end
    n_cmp++; if (wren_n !== 0) begin n_fail++; $display("[TB] FAIL read_wren: got %0d cycles want 0", wren_n); end
    n_cmp++; if (busy_n !== 3) begin n_fail++; $display("[TB] FAIL read_busy: got %0d cycles want 3", busy_n); end
    n_cmp++; if (own !== 1'b0) begin n_fail++; $display("[TB] FAIL read_owner: got %b want 0", own); end
  endtask

  task automatic test_write_read_b();
    int lat, wren_n, busy_n; logic [7:0] dout, waddr; logic own;
    run_access(1'b1, 1'b1, 8'h22, 8'hC3, lat, dout, wren_n, busy_n, waddr, own);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL bwrite_latency: got %0d want 3", lat); end
    n_cmp++; if (wren_n !== 1) begin n_fail++; $display("[TB] FAIL bwrite_wren: got %0d cycles want 1", wren_n); end
    n_cmp++; if (waddr !== 8'h22) begin n_fail++; $display("[TB] FAIL bwrite_addr: got %h want 22", waddr); end
    n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("[TB] FAIL bwrite_dout_held: got %h want 00", dout); end
    run_access(1'b1, 1'b0, 8'h22, 8'h00, lat, dout, wren_n, busy_n, waddr, own);
    n_cmp++; if (dout !== 8'hC3) begin n_fail++; $display("[TB] FAIL bread_dout: got %h want c3", dout); end
    n_cmp++; if (own !== 1'b1) begin n_fail++; $display("[TB] FAIL bread_owner: got %b want 1", own); end
  endtask

  task automatic test_fairness();
    logic [15:0] order; int got;
    logic [9:0] exp_order;
    exp_order = 10'b10_0001_0000;
    do_reset();
    A_Wr = 1'b0; A_Addr = 8'h10; B_Wr = 1'b0; B_Addr = 8'h22;
    A_Req = 1'b1; B_Req = 1'b1;
    collect_grants(10, order, got);
    n_cmp++; if (got !== 10) begin n_fail++; $display("[TB] FAIL fair_count: got %0d grants want 10", got); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (order[i] !== exp_order[i]) begin
        n_fail++; $display("[TB] FAIL fair_grant%0d: got %b want %b", i, order[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_b_stream();
    int acks [3]; int na; int first;
    na = 0; first = -1;
    do_reset();
    B_Wr = 1'b0; B_Addr = 8'h22; B_Req = 1'b1;
    for (int c = 1; c <= 40 && na < 3; c++) begin
      @(negedge Clk);
      if (B_Ack) begin acks[na] = c; na++; end
    end
    n_cmp++; if (na !== 3) begin n_fail++; $display("[TB] FAIL bstream_acks: got %0d want 3", na); end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (acks[i] - acks[i-1] !== 4) begin
        n_fail++; $display("[TB] FAIL bstream_spacing%0d: got %0d want 4", i, acks[i] - acks[i-1]);
      end
    end
    A_Wr = 1'b0; A_Addr = 8'h10; A_Req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (A_Ack) begin first = 0; break; end
      if (B_Ack) begin first = 1; break; end
    end
    A_Req = 1'b0; B_Req = 1'b0;
    n_cmp++; if (first !== 0) begin n_fail++; $display("[TB] FAIL bstream_a_wins: got %0d want 0", first); end
    n_cmp++; if (A_DOut !== 8'h5A) begin n_fail++; $display("[TB] FAIL bstream_a_dout: got %h want 5a", A_DOut); end
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] order; int got;
    do_reset();
    @(negedge Clk);
    A_Wr = 1'b1; A_Addr = 8'h30; A_DIn = 8'h99; A_Req = 1'b1;
    B_Wr = 1'b0; B_Addr = 8'h22; B_Req = 1'b1;
    @(negedge Clk);
    n_cmp++; if (MEM_WrEn !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_issue_wren: got %b want 1", MEM_WrEn); end
    #2 Reset = 1'b0;
    #1;
    n_cmp++;
    if ({MEM_WrEn, Busy, A_Ack} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL midrst_clear: wren/busy/ack got %b want 000", {MEM_WrEn, Busy, A_Ack});
    end
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_idle: busy got %b want 0", Busy); end
    // With the counter back at zero, A gets four grants before B is forced
    collect_grants(5, order, got);
    n_cmp++;
    if (got !== 5 || order[4:0] !== 5'b10000) begin
      n_fail++; $display("[TB] FAIL midrst_counter: order got %b (%0d grants) want 10000", order[4:0], got);
    end
  endtask

  task automatic test_held_req();
    int acks [2]; int na;
    na = 0;
    @(negedge Clk);
    A_Wr = 1'b0; A_Addr = 8'h10; A_Req = 1'b1;
    for (int c = 1; c <= 30 && na < 2; c++) begin
      @(negedge Clk);
      if (A_Ack) begin acks[na] = c; na++; end
    end
    A_Req = 1'b0;
    n_cmp++; if (na !== 2) begin n_fail++; $display("[TB] FAIL held_acks: got %0d want 2", na); end
    n_cmp++; if (acks[0] !== 3) begin n_fail++; $display("[TB] FAIL held_first: got cycle %0d want 3", acks[0]); end
    n_cmp++; if (acks[1] !== 7) begin n_fail++; $display("[TB] FAIL held_second: got cycle %0d want 7", acks[1]); end
    repeat (3) @(negedge Clk);
  endtask

  // Random traffic against a transaction model: one access per arbitration, Ack two edges
  // after the grant, next arbitration four edges after the grant
  task automatic test_random(input int n_cycles);
    int k, e, next_arb, arb_edge, starve, w, cur_port;
    int ack_e [2];
    bit pend [2], req [2], twr [2], exp_ack [2];
    logic [7:0] tad [2], tdt [2], exp_dout [2];
    logic [7:0] cap, cur_addr, cur_din;
    bit cur_wr, exp_busy, exp_wren, exp_owner;
    do_reset();
    for (int i = 0; i < 16; i++) backdoor_write(8'h40 + 8'(i), 8'($urandom));
    k = 0; next_arb = 1; arb_edge = -100; starve = 0; cur_port = 0; cur_wr = 1'b0;
    cur_addr = '0; cur_din = '0; cap = '0;
    exp_busy = 1'b0; exp_wren = 1'b0; exp_owner = 1'b0;
    for (int p = 0; p < 2; p++) begin
      ack_e[p] = -1; pend[p] = 1'b0; req[p] = 1'b0; twr[p] = 1'b0; exp_ack[p] = 1'b0;
      tad[p] = '0; tdt[p] = '0; exp_dout[p] = '0;
    end
    for (int it = 0; it < n_cycles; it++) begin
      n_cmp++; if (A_Ack !== exp_ack[0]) begin n_fail++; $display("[TB] FAIL rand_a_ack @%0d: got %b want %b", k, A_Ack, exp_ack[0]); end
      n_cmp++; if (B_Ack !== exp_ack[1]) begin n_fail++; $display("[TB] FAIL rand_b_ack @%0d: got %b want %b", k, B_Ack, exp_ack[1]); end
      n_cmp++; if (A_DOut !== exp_dout[0]) begin n_fail++; $display("[TB] FAIL rand_a_dout @%0d: got %h want %h", k, A_DOut, exp_dout[0]); end
      n_cmp++; if (B_DOut !== exp_dout[1]) begin n_fail++; $display("[TB] FAIL rand_b_dout @%0d: got %h want %h", k, B_DOut, exp_dout[1]); end
      n_cmp++; if (Busy !== exp_busy) begin n_fail++; $display("[TB] FAIL rand_busy @%0d: got %b want %b", k, Busy, exp_busy); end
      n_cmp++; if (MEM_WrEn !== exp_wren) begin n_fail++; $display("[TB] FAIL rand_wren @%0d: got %b want %b", k, MEM_WrEn, exp_wren); end
      n_cmp++; if (Owner !== exp_owner) begin n_fail++; $display("[TB] FAIL rand_owner @%0d: got %b want %b", k, Owner, exp_owner); end
      if (k == arb_edge) begin
        n_cmp++; if (MEM_Addr !== cur_addr) begin n_fail++; $display("[TB] FAIL rand_mem_addr @%0d: got %h want %h", k, MEM_Addr, cur_addr); end
        if (cur_wr) begin
          n_cmp++; if (MEM_DIn !== cur_din) begin n_fail++; $display("[TB] FAIL rand_mem_din @%0d: got %h want %h", k, MEM_DIn, cur_din); end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && ack_e[p] == k) begin
          pend[p] = 1'b0; req[p] = 1'b0; ack_e[p] = -1;
        end else if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1; req[p] = 1'b1;
          twr[p] = 1'($urandom_range(0, 1));
          tad[p] = 8'h40 + 8'($urandom_range(0, 15));
          tdt[p] = 8'($urandom);
        end
      end
      A_Req = req[0]; A_Wr = twr[0]; A_Addr = tad[0]; A_DIn = tdt[0];
      B_Req = req[1]; B_Wr = twr[1]; B_Addr = tad[1]; B_DIn = tdt[1];
      e = k + 1;
      exp_ack[0] = 1'b0; exp_ack[1] = 1'b0;
      if (e >= next_arb && (req[0] || req[1])) begin
        if (req[0] && req[1]) w = (starve == LIMIT) ? 1 : 0;
        else w = req[1] ? 1 : 0;
        if (w == 1 || !req[1]) starve = 0;
        else if (starve < LIMIT) starve++;
        arb_edge = e; next_arb = e + 4; ack_e[w] = e + 2; cur_port = w;
        cur_wr = twr[w]; cur_addr = tad[w]; cur_din = tdt[w]; exp_owner = (w == 1);
        if (cur_wr) ref_mem[cur_addr] = cur_din;
        else cap = ref_mem[cur_addr];
      end
      exp_busy = (e >= arb_edge) && (e <= arb_edge + 2);
      exp_wren = (e == arb_edge) && cur_wr;
      if (e == arb_edge + 2) begin
        exp_ack[cur_port] = 1'b1;
        if (!cur_wr) exp_dout[cur_port] = cap;
      end
      @(posedge Clk);
      k = e;
      @(negedge Clk);
    end
    A_Req = 1'b0; B_Req = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read_b();
    test_fairness();
    test_b_stream();
    test_reset_mid_write();
    test_held_req();
    test_random(800);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
